// File: rtl/lsu_mem_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_mem_ctrl
// Load/store controller between the execute stage and data_memory.
// It takes one request at a time and forms the effective address as
// base + offset (16-bit, carry discarded). It then drives data_memory, allows
// for the memory's one-cycle synchronous read, and returns the result on a
// valid/ready response channel.
//
// Optional feature (compile-time macro LSU_BOUND_CHECK_EN):
//   defined     : an effective address >= MEM_DEPTH faults. No memory access is
//                 made, and resp_fault=1 with resp_rdata=0.
//   not defined : there is no range check. mem_addr takes the low ADDR_W bits
//                 of the address, so accesses wrap, and resp_fault is always 0.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready request handshake
//   req_wr              1 = store, 0 = load
//   req_base/req_offset address operands (offset is two's complement)
//   req_wdata           store data
//   resp_valid/ready    response handshake
//   resp_rdata          load data (0 for stores and faults)
//   resp_fault          address out of range
//   mem_addr/mem_d_in/mem_wr/mem_d_out  data_memory interface
// -----------------------------------------------------------------------------
module lsu_mem_ctrl #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 5,
  parameter int MEM_DEPTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [DATA_W-1:0] req_base,
  input  logic [DATA_W-1:0] req_offset,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_fault,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_d_in,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_d_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t              state_r;
  logic                wr_r;
  logic                fault_r;
  logic                req_ready_r;
  logic                resp_valid_r;
  logic [DATA_W-1:0]   resp_rdata_r;
  logic                resp_fault_r;
  logic [ADDR_W-1:0]   mem_addr_r;
  logic [DATA_W-1:0]   mem_d_in_r;
  logic                mem_wr_r;

  logic [DATA_W-1:0]   ea_s;
  logic                fault_s;

  // Effective address: the natural DATA_W-bit add drops the carry.
  always_comb begin
    ea_s = req_base + req_offset;
  end

`ifdef LSU_BOUND_CHECK_EN
  // Range check against the number of implemented words.
  always_comb begin
    fault_s = (ea_s >= DATA_W'(MEM_DEPTH));
  end
`else
  // Without the range check, the address bits above ADDR_W are ignored.
  logic unused_ea_hi_s;

  // No fault source; the upper address bits are deliberately dropped.
  always_comb begin
    fault_s        = 1'b0;
    unused_ea_hi_s = ^ea_s[DATA_W-1:ADDR_W];
  end
`endif

  // Controller FSM. All outputs are registered here, so reset clears
  // mem_wr immediately and an interrupted store cannot reach memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= S_IDLE;
      wr_r         <= 1'b0;
      fault_r      <= 1'b0;
      req_ready_r  <= 1'b0;
      resp_valid_r <= 1'b0;
      resp_rdata_r <= {DATA_W{1'b0}};
      resp_fault_r <= 1'b0;
      mem_addr_r   <= {ADDR_W{1'b0}};
      mem_d_in_r   <= {DATA_W{1'b0}};
      mem_wr_r     <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          // req_ready comes up on the first edge after reset release. A
          // request is taken only when req_ready was already visible.
          req_ready_r <= 1'b1;
          if (req_valid && req_ready_r) begin
            wr_r        <= req_wr;
            fault_r     <= fault_s;
            mem_addr_r  <= ea_s[ADDR_W-1:0];
            mem_d_in_r  <= req_wdata;
            mem_wr_r    <= req_wr & ~fault_s;
            req_ready_r <= 1'b0;
            state_r     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // data_memory writes (or starts its read) on this exit edge.
          mem_wr_r <= 1'b0;
          if (fault_r || wr_r) begin
            resp_valid_r <= 1'b1;
            resp_rdata_r <= {DATA_W{1'b0}};
            resp_fault_r <= fault_r;
            state_r      <= S_RESP;
          end else begin
            state_r <= S_WAIT;
          end
        end
        S_WAIT: begin
          resp_valid_r <= 1'b1;
          resp_rdata_r <= mem_d_out;
          resp_fault_r <= 1'b0;
          state_r      <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid_r <= 1'b0;
            req_ready_r  <= 1'b1;
            state_r      <= S_IDLE;
          end
        end
        default: begin
          state_r      <= S_IDLE;
          req_ready_r  <= 1'b0;
          resp_valid_r <= 1'b0;
          mem_wr_r     <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_r;
  assign resp_valid = resp_valid_r;
  assign resp_rdata = resp_rdata_r;
  assign resp_fault = resp_fault_r;
  assign mem_addr   = mem_addr_r;
  assign mem_d_in   = mem_d_in_r;
  assign mem_wr     = mem_wr_r;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for lsu_mem_ctrl. It contains a data_memory model with a
// one-cycle synchronous read, and a transaction-level reference model
// (an array of words plus address/fault arithmetic) that gives the expected
// results. The expected fault behaviour follows LSU_BOUND_CHECK_EN.
// -----------------------------------------------------------------------------
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [15:0] req_base;
  logic [15:0] req_offset;
  logic [15:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_rdata;
  logic        resp_fault;
  logic [4:0]  mem_addr;
  logic [15:0] mem_d_in;
  logic        mem_wr;
  logic [15:0] mem_d_out;

  int n_assert = 0;
  int n_fail   = 0;
  int acc_cnt  = 0;
  int wr_cnt   = 0;
  int exp_acc  = 0;
  int exp_wr   = 0;

  logic [15:0] mem     [32];
  logic [15:0] ref_mem [32];

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.DATA_W(16), .ADDR_W(5), .MEM_DEPTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_base(req_base), .req_offset(req_offset), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_addr(mem_addr), .mem_d_in(mem_d_in), .mem_wr(mem_wr),
    .mem_d_out(mem_d_out)
  );

  function automatic logic [15:0] init_word(input int i);
    if (i == 0)      return 16'h0006;
    else if (i == 1) return 16'h0005;
    else             return 16'h1000 + 16'(i);
  endfunction

  // data_memory model: write on mem_wr, registered read every cycle.
  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr] <= mem_d_in;
    mem_d_out <= mem[mem_addr];
  end

  // Count handshakes and write pulses that the DUT actually presents.
  always @(posedge clk) begin
    if (req_valid && req_ready) acc_cnt <= acc_cnt + 1;
    if (mem_wr) wr_cnt <= wr_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_fault(input logic [15:0] ea);
`ifdef LSU_BOUND_CHECK_EN
    return (ea >= 16'd32);
`else
    return 1'b0;
`endif
  endfunction

  // One complete transaction, entered and left at a negative edge.
  task automatic do_req(input bit wr, input logic [15:0] base, input logic [15:0] off,
                        input logic [15:0] wdata, input int hold, input bit b2b);
    logic [15:0] ea;
    bit          flt;
    int          idx;
    logic [15:0] exp_rd;
    int          waited;
    int          lat;
    int          wr0;
    int          acc0;
    ea     = base + off;
    flt    = model_fault(ea);
    idx    = int'(ea) % 32;
    exp_rd = (wr || flt) ? 16'h0000 : ref_mem[idx];
    req_valid = 1'b1; req_wr = wr; req_base = base; req_offset = off; req_wdata = wdata;
    waited = 0;
    while (!req_ready && waited < 10) begin @(negedge clk); waited++; end
    chk("req_ready_idle", req_ready, 1);
    wr0  = wr_cnt;
    acc0 = acc_cnt;
    @(posedge clk);
    @(negedge clk);
    if (!b2b) req_valid = 1'b0;
    chk("mem_addr", mem_addr, idx);
    chk("mem_d_in", mem_d_in, wdata);
    chk("mem_wr_issue", mem_wr, (wr && !flt) ? 1 : 0);
    lat = 0;
    while (!resp_valid && lat < 8) begin @(negedge clk); lat++; end
    chk("latency", lat, (wr || flt) ? 1 : 2);
    chk("resp_rdata", resp_rdata, exp_rd);
    chk("resp_fault", resp_fault, flt);
    chk("req_ready_busy", req_ready, 0);
    chk("mem_wr_pulses", wr_cnt - wr0, (wr && !flt) ? 1 : 0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", resp_valid, 1);
      chk("hold_rdata", resp_rdata, exp_rd);
      chk("hold_ready", req_ready, 0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("resp_drop", resp_valid, 0);
    chk("back_idle", req_ready, 1);
    chk("rdata_held", resp_rdata, exp_rd);
    chk("one_accept", acc_cnt - acc0, 1);
    exp_acc++;
    if (wr && !flt) begin
      ref_mem[idx] = wdata;
      exp_wr++;
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem[i]     = init_word(i);
      ref_mem[i] = init_word(i);
    end
    rst_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_base = 16'h0;
    req_offset = 16'h0; req_wdata = 16'h0; resp_ready = 1'b0;
    #2;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_resp_fault", resp_fault, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_d_in", mem_d_in, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("ready_after_release", req_ready, 0);
    @(negedge clk);
    chk("ready_first_cycle", req_ready, 1);

    // Directed cases
    do_req(1'b0, 16'h0000, 16'h0001, 16'h0000, 0, 1'b0);  // word1 = 5
    do_req(1'b0, 16'hFFFF, 16'h0002, 16'h0000, 0, 1'b0);  // wrap to ea=1
    do_req(1'b1, 16'h0004, 16'hFFFE, 16'hBEEF, 0, 1'b0);  // store ea=2
    do_req(1'b0, 16'h0002, 16'h0000, 16'h0000, 0, 1'b0);  // load ea=2
    do_req(1'b1, 16'h001F, 16'h0000, 16'hA55A, 0, 1'b0);  // ea=31 valid
    do_req(1'b0, 16'h0000, 16'h001F, 16'h0000, 0, 1'b0);
    do_req(1'b1, 16'h0020, 16'h0000, 16'h7777, 0, 1'b0);  // ea=32
    do_req(1'b0, 16'h0000, 16'h0000, 16'h0000, 0, 1'b0);  // word0
    do_req(1'b0, 16'h0021, 16'h0000, 16'h0000, 0, 1'b0);  // load ea=33

    // Backpressure: a pending request stays on req_valid while the response is held.
    do_req(1'b0, 16'h0002, 16'h0000, 16'h0000, 5, 1'b1);
    req_valid = 1'b0;

    // Reset during ISSUE of a store to ea=3
    req_valid = 1'b1; req_wr = 1'b1; req_base = 16'h0003; req_offset = 16'h0000;
    req_wdata = 16'h1234;
    @(posedge clk);
    exp_acc++;
    #1 req_valid = 1'b0;
    chk("abort_mem_wr_issue", mem_wr, 1);
    #1 rst_n = 1'b0;
    #1 chk("abort_mem_wr_async", mem_wr, 0);
    chk("abort_ready", req_ready, 0);
    repeat (2) begin @(negedge clk); chk("abort_no_resp", resp_valid, 0); end
    rst_n = 1'b1;
    repeat (3) begin @(negedge clk); chk("abort_no_resp_after", resp_valid, 0); end
    do_req(1'b0, 16'h0003, 16'h0000, 16'h0000, 0, 1'b0);

    // Back-to-back stores and loads with req_valid held high
    for (int i = 0; i < 4; i++) begin
      do_req(1'b1, 16'(8 + i), 16'h0000, 16'hC000 + 16'(i), 0, 1'b1);
      do_req(1'b0, 16'h0000, 16'(8 + i), 16'h0000, 0, 1'b1);
    end
    req_valid = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 30; i++) begin
      logic [15:0] ea;
      logic [15:0] off;
      ea  = 16'($urandom_range(0, 40));
      off = 16'($urandom);
      do_req(1'($urandom), ea - off, off, 16'($urandom), $urandom_range(0, 2), 1'b0);
    end

    @(negedge clk);
    chk("total_accepts", acc_cnt, exp_acc);
    chk("total_mem_wr", wr_cnt, exp_wr);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
